// File: rtl/core_pkg.sv
// Shared RV64 core definitions: ALUOp and opcode encodings, default widths, control bundle.
package core_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_AW_DEF = 5;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ADDI = 7'b0010011;
  localparam logic [6:0] OPC_SD   = 7'b0100011;
  localparam logic [6:0] OPC_SB   = 7'b1100011;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the destination of a load in EX.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_valid,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic              i_uses_rs2,
  input  logic              i_id_valid,
  output logic              o_hazard_c
);

  logic w_ex_load;
  logic w_match;

  assign w_ex_load  = i_ex_valid & i_ex_mem_read & (i_ex_rd != '0);
  assign w_match    = (i_ex_rd == i_rs1) | ((i_ex_rd == i_rs2) & i_uses_rs2);
  assign o_hazard_c = w_ex_load & w_match & i_id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Hazard detection is built only when ID_EX_HAZARD_DETECT_EN is defined.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic              branch_i,
  input  logic              mem_read_i,
  input  logic              mem_to_reg_i,
  input  logic              mem_write_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic [1:0]        alu_op_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [3:0]        funct_i,
  input  logic              flush_i,
  output logic              ex_branch_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_mem_write_o,
  output logic              ex_alu_src_o,
  output logic              ex_reg_write_o,
  output logic [1:0]        ex_alu_op_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [3:0]        ex_funct_o,
  output logic              ex_valid_o,
  output logic              stall_o
);

  ctrl_t             w_ctrl_in;
  ctrl_t             w_ctrl_nxt;
  ctrl_t             r_ctrl;
  logic              w_valid_nxt;
  logic              r_valid;
  logic              w_hazard;
  logic              w_kill;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [3:0]        r_funct;

  assign w_ctrl_in = '{branch:     branch_i,
                       mem_read:   mem_read_i,
                       mem_to_reg: mem_to_reg_i,
                       mem_write:  mem_write_i,
                       alu_src:    alu_src_i,
                       reg_write:  reg_write_i,
                       alu_op:     alu_op_i};

`ifdef ID_EX_HAZARD_DETECT_EN
  logic w_uses_rs2;

  // Immediate-form ALU ops ignore rs2; stores still read it as store data.
  assign w_uses_rs2 = ~alu_src_i | mem_write_i;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rd       (r_rd),
    .i_ex_valid    (r_valid),
    .i_rs1         (rs1_i),
    .i_rs2         (rs2_i),
    .i_uses_rs2    (w_uses_rs2),
    .i_id_valid    (id_valid_i),
    .o_hazard_c    (w_hazard)
  );
`else
  assign w_hazard = 1'b0;
`endif

  assign w_kill  = flush_i | w_hazard;
  assign stall_o = w_hazard & ~flush_i;

  // Bubble/flush zero only the control half; mem_to_reg is sanitised for non-writers.
  always_comb begin
    w_ctrl_nxt  = '0;
    w_valid_nxt = 1'b0;
    if (id_valid_i && !w_kill) begin
      w_ctrl_nxt            = w_ctrl_in;
      w_ctrl_nxt.mem_to_reg = mem_to_reg_i & reg_write_i;
      w_valid_nxt           = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_valid    <= w_valid_nxt;
      r_pc       <= pc_i;
      r_rs1_data <= rs1_data_i;
      r_rs2_data <= rs2_data_i;
      r_imm      <= imm_i;
      r_rs1      <= rs1_i;
      r_rs2      <= rs2_i;
      r_rd       <= rd_i;
      r_funct    <= funct_i;
    end
  end

  assign ex_branch_o     = r_ctrl.branch;
  assign ex_mem_read_o   = r_ctrl.mem_read;
  assign ex_mem_to_reg_o = r_ctrl.mem_to_reg;
  assign ex_mem_write_o  = r_ctrl.mem_write;
  assign ex_alu_src_o    = r_ctrl.alu_src;
  assign ex_reg_write_o  = r_ctrl.reg_write;
  assign ex_alu_op_o     = r_ctrl.alu_op;
  assign ex_valid_o      = r_valid;
  assign ex_pc_o         = r_pc;
  assign ex_rs1_data_o   = r_rs1_data;
  assign ex_rs2_data_o   = r_rs2_data;
  assign ex_imm_o        = r_imm;
  assign ex_rs1_o        = r_rs1;
  assign ex_rs2_o        = r_rs2;
  assign ex_rd_o         = r_rd;
  assign ex_funct_o      = r_funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, reset/pass-through sequence,
// and randomized traffic against a reference model. Honours ID_EX_HAZARD_DETECT_EN.
module tb_id_ex_stage;
  import core_pkg::*;

`ifdef ID_EX_HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  localparam logic [7:0] C_R    = 8'h06;
  localparam logic [7:0] C_LD   = 8'h6C;
  localparam logic [7:0] C_ADDI = 8'h0E;
  localparam logic [7:0] C_SD   = 8'h38;
  localparam logic [7:0] E_SD   = 8'h18;
  localparam int unsigned NROWS = 20;

  typedef struct packed {
    logic        valid;
    logic        flush;
    ctrl_t       c;
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } in_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       c;
    logic [63:0] pc;
    logic [63:0] rs1d;
    logic [63:0] rs2d;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } out_t;

  typedef struct {
    in_t        in;
    logic       stall;
    logic       valid;
    logic [7:0] ctrl;
    logic [4:0] rd;
  } vec_t;

  logic        clk, rst_n;
  logic        id_valid_i, branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i;
  logic [1:0]  alu_op_i;
  logic [63:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic [3:0]  funct_i;
  logic        flush_i;
  logic        ex_branch_o, ex_mem_read_o, ex_mem_to_reg_o, ex_mem_write_o, ex_alu_src_o, ex_reg_write_o;
  logic [1:0]  ex_alu_op_o;
  logic [63:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [3:0]  ex_funct_o;
  logic        ex_valid_o, stall_o;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl [NROWS];

  id_ex_stage dut (
    .clk (clk), .rst_n (rst_n), .id_valid_i (id_valid_i),
    .branch_i (branch_i), .mem_read_i (mem_read_i), .mem_to_reg_i (mem_to_reg_i),
    .mem_write_i (mem_write_i), .alu_src_i (alu_src_i), .reg_write_i (reg_write_i),
    .alu_op_i (alu_op_i), .pc_i (pc_i), .rs1_data_i (rs1_data_i), .rs2_data_i (rs2_data_i),
    .imm_i (imm_i), .rs1_i (rs1_i), .rs2_i (rs2_i), .rd_i (rd_i), .funct_i (funct_i),
    .flush_i (flush_i),
    .ex_branch_o (ex_branch_o), .ex_mem_read_o (ex_mem_read_o), .ex_mem_to_reg_o (ex_mem_to_reg_o),
    .ex_mem_write_o (ex_mem_write_o), .ex_alu_src_o (ex_alu_src_o), .ex_reg_write_o (ex_reg_write_o),
    .ex_alu_op_o (ex_alu_op_o), .ex_pc_o (ex_pc_o), .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o), .ex_imm_o (ex_imm_o), .ex_rs1_o (ex_rs1_o), .ex_rs2_o (ex_rs2_o),
    .ex_rd_o (ex_rd_o), .ex_funct_o (ex_funct_o), .ex_valid_o (ex_valid_o), .stall_o (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic [7:0] ctl, input logic [63:0] pc,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [63:0] imm);
    in_t v;
    v       = '0;
    v.valid = 1'b1;
    v.c     = ctrl_t'(ctl);
    v.pc    = pc;
    v.rs1d  = 64'h1000 + 64'(rs1);
    v.rs2d  = 64'h2000 + 64'(rs2);
    v.imm   = imm;
    v.rs1   = rs1;
    v.rs2   = rs2;
    v.rd    = rd;
    return v;
  endfunction

  // Reference model: load-use rule evaluated on the previously issued instruction.
  function automatic logic m_haz(input in_t v, input out_t ex);
    logic uses2;
    uses2 = !v.c.alu_src || v.c.mem_write;
    return HAZ && ex.valid && ex.c.mem_read && (ex.rd != 5'd0) && v.valid &&
           ((ex.rd == v.rs1) || ((ex.rd == v.rs2) && uses2));
  endfunction

  function automatic out_t m_next(input in_t v, input out_t ex);
    out_t n;
    n.pc = v.pc;   n.rs1d = v.rs1d; n.rs2d = v.rs2d; n.imm = v.imm;
    n.rs1 = v.rs1; n.rs2 = v.rs2;   n.rd = v.rd;     n.funct = v.funct;
    n.valid = 1'b0;
    n.c     = '0;
    if (v.valid && !v.flush && !m_haz(v, ex)) begin
      n.valid = 1'b1;
      n.c     = v.c;
      if (!v.c.reg_write) n.c.mem_to_reg = 1'b0;
    end
    return n;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.valid = ex_valid_o;
    o.c     = '{branch: ex_branch_o, mem_read: ex_mem_read_o, mem_to_reg: ex_mem_to_reg_o,
                mem_write: ex_mem_write_o, alu_src: ex_alu_src_o, reg_write: ex_reg_write_o,
                alu_op: ex_alu_op_o};
    o.pc = ex_pc_o;   o.rs1d = ex_rs1_data_o; o.rs2d = ex_rs2_data_o; o.imm = ex_imm_o;
    o.rs1 = ex_rs1_o; o.rs2 = ex_rs2_o;       o.rd = ex_rd_o;         o.funct = ex_funct_o;
    return o;
  endfunction

  task automatic drive(input in_t v);
    id_valid_i = v.valid;        flush_i = v.flush;
    branch_i = v.c.branch;       mem_read_i = v.c.mem_read;   mem_to_reg_i = v.c.mem_to_reg;
    mem_write_i = v.c.mem_write; alu_src_i = v.c.alu_src;     reg_write_i = v.c.reg_write;
    alu_op_i = v.c.alu_op;       pc_i = v.pc;                 rs1_data_i = v.rs1d;
    rs2_data_i = v.rs2d;         imm_i = v.imm;               rs1_i = v.rs1;
    rs2_i = v.rs2;               rd_i = v.rd;                 funct_i = v.funct;
  endtask

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic row(input int i, input in_t v, input logic s, input logic vl,
                     input logic [7:0] c, input logic [4:0] rd);
    tbl[i].in = v; tbl[i].stall = s; tbl[i].valid = vl; tbl[i].ctrl = c; tbl[i].rd = rd;
  endtask

  initial begin
    in_t  v;
    out_t m;

    // ld/use program; hazard rows expect a bubble only when detection is built in
    v = mk(C_R,    64'h100, 5'd3, 5'd4, 5'd5, 64'd0);  row(0,  v, 1'b0, 1'b1, C_R,  5'd5);
    v = mk(C_LD,   64'h104, 5'd2, 5'd0, 5'd5, 64'd8);  row(1,  v, 1'b0, 1'b1, C_LD, 5'd5);
    v = mk(C_R,    64'h108, 5'd5, 5'd7, 5'd6, 64'd0);  row(2,  v, HAZ, !HAZ, HAZ ? 8'h00 : C_R, 5'd6);
                                                       row(3,  v, 1'b0, 1'b1, C_R,  5'd6);
    v = mk(C_LD,   64'h10C, 5'd2, 5'd0, 5'd0, 64'd0);  row(4,  v, 1'b0, 1'b1, C_LD, 5'd0);
    v = mk(C_R,    64'h110, 5'd0, 5'd0, 5'd1, 64'd0);  row(5,  v, 1'b0, 1'b1, C_R,  5'd1);
    v = mk(C_LD,   64'h114, 5'd2, 5'd0, 5'd5, 64'd0);  row(6,  v, 1'b0, 1'b1, C_LD, 5'd5);
    v = mk(C_ADDI, 64'h118, 5'd9, 5'd5, 5'd6, 64'd1);  row(7,  v, 1'b0, 1'b1, C_ADDI, 5'd6);
    v = mk(C_LD,   64'h11C, 5'd2, 5'd0, 5'd5, 64'd0);  row(8,  v, 1'b0, 1'b1, C_LD, 5'd5);
    v = mk(C_R,    64'h120, 5'd5, 5'd7, 5'd6, 64'd0);  v.flush = 1'b1;
                                                       row(9,  v, 1'b0, 1'b0, 8'h00, 5'd6);
    v = mk(C_SD,   64'h200, 5'd2, 5'd5, 5'd0, 64'd0);  row(10, v, 1'b0, 1'b1, E_SD, 5'd0);
    v = mk(C_LD,   64'h204, 5'd2, 5'd0, 5'd5, 64'd0);  row(11, v, 1'b0, 1'b1, C_LD, 5'd5);
    v = mk(C_SD,   64'h208, 5'd3, 5'd5, 5'd0, 64'd0);  row(12, v, HAZ, !HAZ, HAZ ? 8'h00 : E_SD, 5'd0);
                                                       row(13, v, 1'b0, 1'b1, E_SD, 5'd0);
    v = mk(C_LD,   64'h20C, 5'd2, 5'd0, 5'd5, 64'd0);  row(14, v, 1'b0, 1'b1, C_LD, 5'd5);
    v = mk(C_LD,   64'h210, 5'd5, 5'd0, 5'd6, 64'd0);  row(15, v, HAZ, !HAZ, HAZ ? 8'h00 : C_LD, 5'd6);
                                                       row(16, v, 1'b0, 1'b1, C_LD, 5'd6);
    v = mk(C_R,    64'h214, 5'd6, 5'd0, 5'd7, 64'd0);  row(17, v, HAZ, !HAZ, HAZ ? 8'h00 : C_R, 5'd7);
                                                       row(18, v, 1'b0, 1'b1, C_R,  5'd7);
    v = mk(C_R,    64'h218, 5'd7, 5'd7, 5'd8, 64'd0);  v.valid = 1'b0;
                                                       row(19, v, 1'b0, 1'b0, 8'h00, 5'd8);

    rst_n = 1'b0;
    drive('0);
    #3;
    chk("reset_out", 320'(dut_out()), 320'(0));
    chk("reset_stall", 320'(stall_o), 320'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < int'(NROWS); i++) begin
      drive(tbl[i].in);
      #1;
      chk($sformatf("row%0d_stall", i), 320'(stall_o), 320'(tbl[i].stall));
      @(posedge clk); #1;
      chk($sformatf("row%0d_valid", i), 320'(ex_valid_o), 320'(tbl[i].valid));
      chk($sformatf("row%0d_ctrl", i), 320'(8'(dut_out().c)), 320'(tbl[i].ctrl));
      chk($sformatf("row%0d_rd", i), 320'(ex_rd_o), 320'(tbl[i].rd));
    end

    // Exact pass-through of an R-type, then asynchronous reset between edges
    v = mk(C_R, 64'h100, 5'd3, 5'd4, 5'd5, 64'd0);
    v.funct = 4'h8;
    drive(v);
    @(posedge clk); #1;
    chk("pass_pc",    320'(ex_pc_o),       320'(64'h100));
    chk("pass_rs1d",  320'(ex_rs1_data_o), 320'(64'h1003));
    chk("pass_rs2d",  320'(ex_rs2_data_o), 320'(64'h2004));
    chk("pass_idx",   320'({ex_rs1_o, ex_rs2_o, ex_rd_o}), 320'({5'd3, 5'd4, 5'd5}));
    chk("pass_funct", 320'(ex_funct_o),    320'(4'h8));
    chk("pass_ctrl",  320'({ex_valid_o, 8'(dut_out().c)}), 320'({1'b1, C_R}));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out",   320'(dut_out()), 320'(0));
    chk("async_rst_stall", 320'(stall_o),   320'(0));
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_hold", 320'(dut_out()), 320'(0));
    @(posedge clk); #1;
    chk("post_rst_load", 320'({ex_valid_o, ex_rd_o}), 320'({1'b1, 5'd5}));

    // Randomized traffic with a narrow register range to provoke frequent hazards
    rst_n = 1'b0;
    drive('0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m = '0;
    for (int n = 0; n < 400; n++) begin
      logic exp_stall;
      v        = '0;
      v.valid  = ($urandom_range(0, 9) != 0);
      v.flush  = ($urandom_range(0, 9) == 0);
      v.c      = ctrl_t'(8'($urandom));
      v.pc     = {$urandom, $urandom};
      v.rs1d   = {$urandom, $urandom};
      v.rs2d   = {$urandom, $urandom};
      v.imm    = {$urandom, $urandom};
      v.rs1    = 5'($urandom_range(0, 3));
      v.rs2    = 5'($urandom_range(0, 3));
      v.rd     = 5'($urandom_range(0, 3));
      v.funct  = 4'($urandom);
      drive(v);
      #1;
      exp_stall = m_haz(v, m) && !v.flush;
      chk($sformatf("rnd%0d_stall", n), 320'(stall_o), 320'(exp_stall));
      m = m_next(v, m);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_out", n), 320'(dut_out()), 320'(m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage RV64 core. It sits directly downstream of the decode control unit and captures that unit's control bits together with the decoded operands, PC and register indices for the EX stage. It contains the load-use hazard detector, which stalls PC and IF/ID and inserts a bubble into EX. It also squashes the decode instruction when EX/MEM reports a taken branch.

## Interface
Parameters:
- XLEN, 64, datapath width for PC, register data and immediate.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  decode slot holds a real instruction.
- branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i  in  1 each  control bits from the decode control unit.
- alu_op_i  in  2  ALUOp from the control unit.
- pc_i  in  XLEN  PC of the decode instruction.
- rs1_data_i, rs2_data_i  in  XLEN  register-file read data.
- imm_i  in  XLEN  sign-extended immediate.
- rs1_i, rs2_i, rd_i  in  REG_AW  register indices.
- funct_i  in  4  {funct7[5], funct3} for the ALU control.
- flush_i  in  1  taken branch resolved downstream; kill the decode slot.
- ex_* (one per captured input, same names with ex_ prefix and _o suffix)  out  same widths  registered EX-stage copies.
- ex_valid_o  out  1  EX slot holds a real instruction.
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.

## Operation
- Single register bank. Each rising clk edge selects one of three actions:
  - **load**: all fields are captured from the inputs.
  - **bubble**: control bits, alu_op and valid are forced to 0; data and index fields are still captured.
  - **flush**: same effect as bubble.
- Action priority: reset, then flush_i, then hazard, then load.
- X-sanitise: when reg_write_i=0, ex_mem_to_reg is captured as 0, because the control unit drives X for stores and branches.
- Control bits are qualified by validity: if id_valid_i=0, the control bits and valid are captured as 0.
- Hazard condition (all terms must hold):
  - ex_valid_o=1, ex_mem_read_o=1, ex_rd_o≠0 and id_valid_i=1.
  - ex_rd_o==rs1_i, or (ex_rd_o==rs2_i and uses_rs2).
  - uses_rs2 = !alu_src_i | mem_write_i.
- stall_o = hazard & !flush_i. A flush cancels the stall.
- A hazard inserts a bubble. The decode instruction is held upstream and re-presented next cycle, when the hazard has cleared because EX now holds the bubble.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on ex_* after edge N.
- Reset is asynchronous. Every output resets to 0 immediately on rst_n low, including stall_o, since ex_valid_o=0. Outputs stay at 0 until the first edge after rst_n rises.
- A load-use pair produces exactly one bubble cycle; stall_o is high for exactly one cycle.
- flush_i and hazard in the same cycle: flush only, stall_o=0, and no re-presentation is expected.
- rd=x0 as the load destination never stalls.
- Back-to-back loads with a dependency: each pair stalls independently. stall_o never stays asserted for 2 consecutive cycles from the same EX load.

## Configuration
- ID_EX_HAZARD_DETECT_EN
  - Defined: load-use detection and bubble insertion behave as described above.
  - Undefined: stall_o is tied to 0, the hazard term is constant 0, and the register does only load and flush. Software scheduling or forwarding is relied on instead.

## Structure
- Shared package core_pkg:
  - ALUOp encodings: ALUOP_MEM=2'b00, ALUOP_BR=2'b01, ALUOP_R=2'b10.
  - Opcode constants: R, LD, ADDI, SD, SB.
  - XLEN and REG_AW defaults.
  - A packed struct ctrl_t bundling the six control bits and alu_op.
- One sub-module, hazard_detect: purely combinational. It takes ex_mem_read, ex_rd, ex_valid, rs1, rs2, uses_rs2 and id_valid, and produces the hazard signal. It is instantiated only under ID_EX_HAZARD_DETECT_EN.

## Test plan
- Reset mid-stream: load an R-type, then pull rst_n low between edges. All ex_* outputs and stall_o must be 0 immediately, without waiting for a clock edge.
- Plain pass-through: R-type add with rs1=3, rs2=4, rd=5, reg_write=1, alu_op=2'b10, pc=0x100. One edge later, ex_* must equal the inputs exactly and ex_valid_o=1.
- Load-use hazard: ld x5,8(x2) followed by add x6,x5,x7.
  - The cycle after the ld enters EX: stall_o=1.
  - Next edge: ex_valid_o=0 and all control bits 0.
  - Following edge: the add appears with ex_valid_o=1.
- No false stalls:
  - ld x0 followed by a use of x0: stall_o=0.
  - ld x5 followed by addi x6,x9,1 where rs2 field=5: stall_o=0, because uses_rs2=0.
- Flush with simultaneous hazard: ld x5 in EX, dependent add in ID, flush_i=1. Required: stall_o=0, and after the edge ex_valid_o=0 and ex_reg_write_o=0.
- Store X-sanitise: sd with mem_to_reg_i=X and reg_write_i=0. Required: ex_mem_to_reg_o=0 (not X), ex_mem_write_o=1, ex_alu_src_o=1.
